// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core/debug request ports, RAM side and access counters of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int N = 1024,
  parameter int CNT_W = 16
);
  localparam int n = $clog2(N);
  logic c_req, c_we, c_gnt, c_rvalid;
  logic [n-1:0] c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [n-1:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [n-1:0] ram_addr;
  logic ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  logic [CNT_W-1:0] c_cnt, d_cnt;
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input c_gnt, c_rdata, c_rvalid, d_gnt, d_rdata, d_rvalid, ram_addr, ram_we, ram_wdata, c_cnt, d_cnt
  );
  modport slave (
    input c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output c_gnt, c_rdata, c_rvalid, d_gnt, d_rdata, d_rvalid, ram_addr, ram_we, ram_wdata, c_cnt, d_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port data RAM between core port C and debug port D
module dmem_arbiter #(
  parameter int N = 1024,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RST,
  dmem_arbiter_if.slave bus
);
  localparam int n = $clog2(N);
  localparam logic [CNT_W-1:0] cmax = '1;
  typedef enum logic [1:0] {IDLE, ACC_C, ACC_D} state_t;
  state_t state, state_n;
  logic last, acc_c, acc_d;
  logic [n-1:0] addr;
  // last=1 means D was served last, so C wins the next tie
  always_comb begin
    acc_c = state == ACC_C;
    acc_d = state == ACC_D;
    state_n = acc_c ? (bus.d_req ? ACC_D : IDLE) :
              acc_d ? (bus.c_req ? ACC_C : IDLE) :
              (bus.c_req && (!bus.d_req || last)) ? ACC_C :
              bus.d_req ? ACC_D : IDLE;
    addr = acc_c ? bus.c_addr : acc_d ? bus.d_addr : '0;
    bus.ram_addr = addr;
    bus.ram_wdata = acc_c ? bus.c_wdata : acc_d ? bus.d_wdata : '0;
    bus.ram_we = ((acc_c && bus.c_we) || (acc_d && bus.d_we)) && !RST;
    bus.c_gnt = acc_c;
    bus.d_gnt = acc_d;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      last <= 1'b1;
      bus.c_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.c_rdata <= '0;
      bus.d_rdata <= '0;
      bus.c_cnt <= '0;
      bus.d_cnt <= '0;
    end else begin
      state <= state_n;
      if (acc_c) last <= 1'b0;
      if (acc_d) last <= 1'b1;
      bus.c_rvalid <= acc_c && !bus.c_we;
      bus.d_rvalid <= acc_d && !bus.d_we;
      if (acc_c && !bus.c_we) bus.c_rdata <= bus.ram_rdata;
      if (acc_d && !bus.d_we) bus.d_rdata <= bus.ram_rdata;
      if (acc_c && bus.c_cnt != cmax) bus.c_cnt <= bus.c_cnt + 1'b1;
      if (acc_d && bus.d_cnt != cmax) bus.d_cnt <= bus.d_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenario tasks with hand-computed expectations and a behavioural RAM
module tb_dmem_arbiter;
  localparam int N = 1024;
  localparam int CNT_W = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:N-1];
  dmem_arbiter_if #(.N(N), .CNT_W(CNT_W)) bus ();
  dmem_arbiter #(.N(N), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge CLK) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1;
    step();
    step();
    RST = 0;
  endtask

  task automatic d_write(input logic [9:0] a, input logic [31:0] w);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = a; bus.d_wdata = w;
    step();
    step();
    bus.d_req = 0; bus.d_we = 0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    step();
    @(negedge CLK);
    checks++; if ({bus.c_gnt, bus.d_gnt, bus.ram_we} !== 3'b000) begin failures++; $display("FAIL reset_gnt_we got=%b exp=000", {bus.c_gnt, bus.d_gnt, bus.ram_we}); end
    step();
    RST = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++; if ({bus.c_gnt, bus.d_gnt, bus.ram_we, bus.c_rvalid, bus.d_rvalid} !== 5'b0) begin failures++; $display("FAIL idle_ctrl got=%b exp=00000", {bus.c_gnt, bus.d_gnt, bus.ram_we, bus.c_rvalid, bus.d_rvalid}); end
      checks++; if ({bus.c_rdata, bus.d_rdata, bus.c_cnt, bus.d_cnt, bus.ram_addr, bus.ram_wdata} !== '0) begin failures++; $display("FAIL idle_data got=%h exp=0", {bus.c_rdata, bus.d_rdata, bus.c_cnt, bus.d_cnt, bus.ram_addr, bus.ram_wdata}); end
      step();
    end
  endtask

  task automatic test_d_write_c_read();
    do_reset();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 10'h010; bus.d_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (bus.d_gnt !== 1'b0) begin failures++; $display("FAIL dw_gnt_t0 got=%b exp=0", bus.d_gnt); end
    step();
    @(negedge CLK);
    checks++; if ({bus.d_gnt, bus.c_gnt, bus.ram_we} !== 3'b101) begin failures++; $display("FAIL dw_gnt_we got=%b exp=101", {bus.d_gnt, bus.c_gnt, bus.ram_we}); end
    checks++; if (bus.ram_addr !== 10'h010 || bus.ram_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL dw_ram_bus got=%h/%h exp=010/deadbeef", bus.ram_addr, bus.ram_wdata); end
    step();
    bus.d_req = 0; bus.d_we = 0;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 10'h010;
    @(negedge CLK);
    checks++; if ({bus.d_gnt, bus.c_gnt, bus.ram_we} !== 3'b000) begin failures++; $display("FAIL dw_after got=%b exp=000", {bus.d_gnt, bus.c_gnt, bus.ram_we}); end
    checks++; if (mem[10'h010] !== 32'hDEADBEEF) begin failures++; $display("FAIL dw_mem got=%h exp=deadbeef", mem[10'h010]); end
    step();
    @(negedge CLK);
    checks++; if ({bus.c_gnt, bus.c_rvalid, bus.ram_we} !== 3'b100) begin failures++; $display("FAIL cr_gnt got=%b exp=100", {bus.c_gnt, bus.c_rvalid, bus.ram_we}); end
    step();
    bus.c_req = 0;
    @(negedge CLK);
    checks++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cr_rdata got=%b/%h exp=1/deadbeef", bus.c_rvalid, bus.c_rdata); end
    checks++; if (bus.c_cnt !== 4'd1 || bus.d_cnt !== 4'd1 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL cr_cnts got=%0d/%0d/%b exp=1/1/0", bus.c_cnt, bus.d_cnt, bus.d_rvalid); end
    step();
    @(negedge CLK);
    checks++; if (bus.c_rvalid !== 1'b0 || bus.c_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cr_hold got=%b/%h exp=0/deadbeef", bus.c_rvalid, bus.c_rdata); end
  endtask

  task automatic test_simultaneous();
    d_write(10'h011, 32'h12345678);
    do_reset();
    bus.c_req = 1; bus.c_addr = 10'h010;
    bus.d_req = 1; bus.d_addr = 10'h011;
    @(negedge CLK);
    checks++; if ({bus.c_gnt, bus.d_gnt} !== 2'b00) begin failures++; $display("FAIL sim_t0 got=%b exp=00", {bus.c_gnt, bus.d_gnt}); end
    for (int k = 1; k <= 8; k++) begin
      step();
      @(negedge CLK);
      checks++; if ({bus.c_gnt, bus.d_gnt} !== {k[0], ~k[0]}) begin failures++; $display("FAIL sim_alt k=%0d got=%b exp=%b", k, {bus.c_gnt, bus.d_gnt}, {k[0], ~k[0]}); end
      checks++; if ({bus.c_rvalid, bus.d_rvalid} !== {k >= 2 && !k[0], k >= 3 && k[0]}) begin failures++; $display("FAIL sim_rvalid k=%0d got=%b", k, {bus.c_rvalid, bus.d_rvalid}); end
      if (k == 3) begin
        checks++; if (bus.c_rdata !== 32'hDEADBEEF || bus.d_rdata !== 32'h12345678) begin failures++; $display("FAIL sim_rdata got=%h/%h exp=deadbeef/12345678", bus.c_rdata, bus.d_rdata); end
      end
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_lone();
    do_reset();
    bus.c_req = 1; bus.c_addr = 10'h011;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      @(negedge CLK);
      checks++; if ({bus.c_gnt, bus.d_gnt, bus.ram_we} !== {k[0], 2'b00}) begin failures++; $display("FAIL lone k=%0d got=%b exp=%b", k, {bus.c_gnt, bus.d_gnt, bus.ram_we}, {k[0], 2'b00}); end
      if (!k[0]) begin
        checks++; if (bus.ram_addr !== '0) begin failures++; $display("FAIL lone_addr k=%0d got=%h exp=0", k, bus.ram_addr); end
      end
    end
    step();
    bus.c_req = 0;
    @(negedge CLK);
    checks++; if (bus.c_cnt !== 4'd5 || bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'h12345678) begin failures++; $display("FAIL lone_end got=%0d/%b/%h exp=5/1/12345678", bus.c_cnt, bus.c_rvalid, bus.c_rdata); end
  endtask

  task automatic test_reset_mid_access();
    d_write(10'h020, 32'h0);
    do_reset();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 10'h020; bus.d_wdata = 32'hCAFEF00D;
    step();
    @(negedge CLK);
    checks++; if (bus.d_gnt !== 1'b1) begin failures++; $display("FAIL rst_w_gnt got=%b exp=1", bus.d_gnt); end
    RST = 1;
    #1;
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL rst_w_we got=%b exp=0", bus.ram_we); end
    step();
    RST = 0;
    clear_inputs();
    @(negedge CLK);
    checks++; if (mem[10'h020] !== 32'h0) begin failures++; $display("FAIL rst_w_mem got=%h exp=0", mem[10'h020]); end
    checks++; if ({bus.d_gnt, bus.c_gnt} !== 2'b00 || bus.d_cnt !== 4'd0) begin failures++; $display("FAIL rst_w_idle got=%b/%0d exp=00/0", {bus.d_gnt, bus.c_gnt}, bus.d_cnt); end
    bus.c_req = 1; bus.c_addr = 10'h010;
    step();
    @(negedge CLK);
    checks++; if (bus.c_gnt !== 1'b1) begin failures++; $display("FAIL rst_r_gnt got=%b exp=1", bus.c_gnt); end
    RST = 1;
    step();
    RST = 0;
    clear_inputs();
    @(negedge CLK);
    checks++; if (bus.c_rvalid !== 1'b0 || bus.c_rdata !== 32'h0 || bus.c_cnt !== 4'd0) begin failures++; $display("FAIL rst_r got=%b/%h/%0d exp=0/0/0", bus.c_rvalid, bus.c_rdata, bus.c_cnt); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    do_reset();
    exp_cnt = 4'd0;
    bus.c_req = 1; bus.c_addr = 10'h010;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      @(negedge CLK);
      checks++; if (bus.c_cnt !== exp_cnt) begin failures++; $display("FAIL sat k=%0d got=%0d exp=%0d", k, bus.c_cnt, exp_cnt); end
      if (k[0] && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
    end
    step();
    bus.c_req = 0;
    @(negedge CLK);
    checks++; if (bus.c_cnt !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", bus.c_cnt); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_d_write_c_read();
    test_simultaneous();
    test_lone();
    test_reset_mid_access();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
